mips_fetch_unit: RTL and testbench

Program-counter and fetch-control stage directly upstream of the 16-bit instruction memory. It drives the memory's 32-bit word address. The memory has 1-cycle synchronous-read latency; this block keeps the PC of the instruction currently on the memory output aligned with it. It applies stall, branch, jump and halt requests from decode, and flags fetches beyond the end of instruction memory.

---
 rtl/mips_fetch_unit.sv | 139 +++++++++++++
 tb/tb_mips_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// Fetch stage for a 1-cycle synchronous instruction memory. Tracks the PC of the word
// currently on the memory output, and applies stall, branch, jump and halt requests with
// zero redirect bubbles. Fetches beyond the last valid word trap into a sticky fault.
module mips_fetch_unit #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned IMEM_DEPTH = 35,
  parameter int unsigned BR_OFF_W   = 6,
  parameter int unsigned JMP_W      = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                branch_taken_i,
  input  logic [BR_OFF_W-1:0] branch_offset_i,
  input  logic                jump_i,
  input  logic [JMP_W-1:0]    jump_target_i,
  input  logic                halt_i,
  output logic [PC_W-1:0]     pc_o,
  output logic [PC_W-1:0]     inst_pc_o,
  output logic [PC_W-1:0]     pc_plus1_o,
  output logic                inst_valid_o,
  output logic                halted_o,
  output logic                fault_o
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt, StFault} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;

  logic            accept;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target_ext;
  logic [PC_W-1:0] target;
  logic            target_oor;

  // Redirect target selection; jump outranks branch, both only on an accepted instruction.
  always_comb begin
    accept          = (state_q == StRun) && inst_valid_q && !stall_i;
    branch_target   = inst_pc_q + PC_W'(1)
                    + {{(PC_W-BR_OFF_W){branch_offset_i[BR_OFF_W-1]}}, branch_offset_i};
    jump_target_ext = {{(PC_W-JMP_W){1'b0}}, jump_target_i};
    if (accept && jump_i) begin
      target = jump_target_ext;
    end else if (accept && branch_taken_i) begin
      target = branch_target;
    end else begin
      target = fetch_pc_q;
    end
    // Negative branch results wrap high and land here too.
    target_oor = (target >= PC_W'(IMEM_DEPTH));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; halt wins over the range check.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (accept && halt_i) begin
          state_d = StHalt;
        end else if (accept && target_oor) begin
          state_d = StFault;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Datapath next-state; everything holds on stall and in the terminal states.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;
    fault_d      = fault_q;
    if (state_q == StBoot) begin
      inst_pc_d    = '0;
      fetch_pc_d   = PC_W'(1);
      inst_valid_d = 1'b1;
    end else if (accept) begin
      if (halt_i) begin
        halted_d     = 1'b1;
        inst_valid_d = 1'b0;
      end else if (target_oor) begin
        fault_d      = 1'b1;
        inst_valid_d = 1'b0;
      end else begin
        inst_pc_d  = target;
        fetch_pc_d = target + PC_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  // Memory address mux; anything not advancing re-reads inst_pc so the output stays stable.
  always_comb begin
    unique case (state_q)
      StBoot:  pc_o = fetch_pc_q;
      StRun:   pc_o = (accept && !halt_i && !target_oor) ? target : inst_pc_q;
      default: pc_o = inst_pc_q;
    endcase
    inst_pc_o    = inst_pc_q;
    pc_plus1_o   = inst_pc_q + PC_W'(1);
    inst_valid_o = inst_valid_q;
    halted_o     = halted_q;
    fault_o      = fault_q;
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios pinned with literal values, then random
// stall/branch/jump/halt/reset traffic compared every cycle against a behavioural model.
module tb_mips_fetch_unit;

  localparam int unsigned Depth = 35;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, br, jmp, hlt;
  logic [5:0]  off;
  logic [11:0] jt;
  logic [31:0] pc, inst_pc, pc_plus1;
  logic        inst_valid, halted, fault;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: mode 0=boot 1=run 2=halted 3=faulted.
  int          m_mode;
  logic [31:0] m_next, m_ipc;
  logic        m_valid, m_halted, m_fault;

  mips_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall),
    .branch_taken_i  (br),
    .branch_offset_i (off),
    .jump_i          (jmp),
    .jump_target_i   (jt),
    .halt_i          (hlt),
    .pc_o            (pc),
    .inst_pc_o       (inst_pc),
    .pc_plus1_o      (pc_plus1),
    .inst_valid_o    (inst_valid),
    .halted_o        (halted),
    .fault_o         (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_next = 0; m_ipc = 0; m_valid = 0; m_halted = 0; m_fault = 0;
  endfunction

  // Address the instruction after m_ipc would come from, before the range check.
  function automatic logic [31:0] redirect();
    if (jmp) return {20'd0, jt};
    if (br) return m_ipc + 32'd1 + 32'(int'($signed(off)));
    return m_next;
  endfunction

  function automatic logic [31:0] model_pc();
    logic [31:0] t;
    if (m_mode == 0) return m_next;
    if (m_mode != 1 || stall || hlt) return m_ipc;
    t = redirect();
    return (t >= Depth) ? m_ipc : t;
  endfunction

  function automatic void model_edge();
    logic [31:0] t;
    if (m_mode == 0) begin
      m_ipc = 0; m_next = 1; m_valid = 1; m_mode = 1;
    end else if (m_mode == 1 && !stall) begin
      if (hlt) begin
        m_mode = 2; m_halted = 1; m_valid = 0;
      end else begin
        t = redirect();
        if (t >= Depth) begin
          m_mode = 3; m_fault = 1; m_valid = 0;
        end else begin
          m_ipc = t; m_next = t + 1;
        end
      end
    end
  endfunction

  task automatic compare_all();
    chk("pc", pc, model_pc());
    chk("inst_pc", inst_pc, m_ipc);
    chk("pc_plus1", pc_plus1, m_ipc + 32'd1);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("fault", {31'd0, fault}, {31'd0, m_fault});
  endtask

  // Entered and left at posedge+1; outputs sampled mid-cycle, model advanced on the edge.
  task automatic step(input logic s, input logic b, input logic [5:0] o, input logic j,
                      input logic [11:0] t, input logic h, output logic [31:0] pc_seen);
    stall = s; br = b; off = o; jmp = j; jt = t; hlt = h;
    #2;
    pc_seen = pc;
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    logic [31:0] p;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 1'b0, 12'd0, 1'b0, p);
  endtask

  // Asynchronous assertion mid-cycle, synchronous-looking release at posedge+1.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_pc", pc, 32'd0);
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] p;
    stall = 0; br = 0; off = 0; jmp = 0; jt = 0; hlt = 0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Boot and sequential fetch.
    step(1'b0, 1'b0, 6'd0, 1'b0, 12'd0, 1'b0, p);
    chk("boot_pc", p, 32'd0);
    chk("boot_valid", {31'd0, inst_valid}, 32'd1);
    idle(3);
    chk("seq_inst_pc", inst_pc, 32'd3);
    chk("seq_plus1", pc_plus1, 32'd4);

    // Stall holds instruction 3.
    step(1'b1, 1'b0, 6'd0, 1'b0, 12'd0, 1'b0, p);
    chk("stall_pc", p, 32'd3);
    step(1'b1, 1'b1, 6'd5, 1'b1, 12'd9, 1'b1, p);
    chk("stall_ignores", p, 32'd3);
    chk("stall_hold", inst_pc, 32'd3);
    step(1'b0, 1'b0, 6'd0, 1'b0, 12'd0, 1'b0, p);
    chk("post_stall_pc", p, 32'd4);
    idle(1);
    chk("at5", inst_pc, 32'd5);

    // Backward branch -3 from 5.
    step(1'b0, 1'b1, 6'b111101, 1'b0, 12'd0, 1'b0, p);
    chk("branch_pc", p, 32'd3);
    chk("branch_ipc", inst_pc, 32'd3);
    idle(1);
    chk("branch_seq", inst_pc, 32'd4);

    // Jump beats branch.
    do_reset();
    idle(3);
    step(1'b0, 1'b1, 6'd1, 1'b1, 12'd20, 1'b0, p);
    chk("jump_pc", p, 32'd20);
    chk("jump_ipc", inst_pc, 32'd20);
    step(1'b0, 1'b0, 6'd0, 1'b0, 12'd0, 1'b0, p);
    chk("jump_next", p, 32'd21);

    // Sequential run off the end of memory.
    do_reset();
    idle(35);
    chk("at34", inst_pc, 32'd34);
    step(1'b0, 1'b0, 6'd0, 1'b0, 12'd0, 1'b0, p);
    chk("oor_pc", p, 32'd34);
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_invalid", {31'd0, inst_valid}, 32'd0);
    idle(5);
    chk("fault_held", pc, 32'd34);
    do_reset();

    // Halt blocked by stall, then taken over a branch.
    idle(8);
    chk("at7", inst_pc, 32'd7);
    step(1'b1, 1'b0, 6'd0, 1'b0, 12'd0, 1'b1, p);
    chk("halt_stalled", {31'd0, halted}, 32'd0);
    step(1'b0, 1'b1, 6'd5, 1'b0, 12'd0, 1'b1, p);
    chk("halt_pc", p, 32'd7);
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_invalid", {31'd0, inst_valid}, 32'd0);
    idle(3);
    chk("halt_frozen", pc, 32'd7);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ((m_mode >= 2 && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, 6'($urandom),
             $urandom_range(0, 9) == 0, 12'($urandom_range(0, 40)),
             $urandom_range(0, 49) == 0, p);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
